// File: rtl/bcd_seg_scanner.sv
// Two-digit multiplexed 7-segment driver: per-frame shadow capture, blank gap
// between digits, optional leading-zero blanking. All outputs registered.
module bcd_seg_scanner #(
   parameter int unsigned SLOT_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cnt_zero,
   input  logic [3:0] cnt_one,
   input  logic       blank_lz,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       frame_done
);

   localparam int unsigned SC_W = $clog2(SLOT_CYCLES);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SLOT_CYCLES - 1);
   localparam logic [6:0] SEG_OFF = 7'h7F;

   typedef enum logic {
      ST_RESTART,
      ST_RUN
   } state_t;

   state_t          state, state_n;
   logic [SC_W-1:0] sc, sc_n;
   logic            ss, ss_n;
   logic [7:0]      shadow, shadow_n;
   logic [6:0]      seg_n;
   logic [1:0]      an_n;
   logic            frame_done_n;

   // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD shows a dash.
   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = 7'h3F;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_RESTART;
         sc         <= '0;
         ss         <= 1'b0;
         shadow     <= 8'h00;
         seg        <= SEG_OFF;
         an         <= 2'b11;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         sc         <= sc_n;
         ss         <= ss_n;
         shadow     <= shadow_n;
         seg        <= seg_n;
         an         <= an_n;
         frame_done <= frame_done_n;
      end
   end

   // Outputs are decoded from the next position so they land with the edge that enters it.
   always_comb begin
      state_n      = ST_RUN;
      sc_n         = sc;
      ss_n         = ss;
      shadow_n     = shadow;
      seg_n        = SEG_OFF;
      an_n         = 2'b11;
      frame_done_n = 1'b0;

      if (state == ST_RESTART || (ss && sc == SC_LAST)) begin
         sc_n     = '0;
         ss_n     = 1'b0;
         shadow_n = {cnt_one, cnt_zero};
      end else if (sc == SC_LAST) begin
         sc_n = '0;
         ss_n = 1'b1;
      end else begin
         sc_n = sc + SC_W'(1);
      end

      // Slot position 0 stays blank to suppress ghosting.
      if (sc_n != '0) begin
         if (!ss_n) begin
            an_n  = 2'b10;
            seg_n = decode(shadow_n[3:0]);
         end else if (!(blank_lz && shadow_n[7:4] == 4'd0)) begin
            an_n  = 2'b01;
            seg_n = decode(shadow_n[7:4]);
         end
      end

      frame_done_n = ss_n && (sc_n == SC_LAST);
   end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Self-checking bench for bcd_seg_scanner: directed scenarios plus randomized
// traffic, checked against a frame-position model.
module tb_bcd_seg_scanner;

   localparam int S = 4;
   localparam int FRAME = 2 * S;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cnt_zero;
   logic [3:0] cnt_one;
   logic       blank_lz;
   logic [6:0] seg;
   logic [1:0] an;
   logic       frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: position -1 means "held in reset / restart pending".
   int         m_p = -1;
   logic [3:0] m_ones = 4'd0;
   logic [3:0] m_tens = 4'd0;

   bcd_seg_scanner #(.SLOT_CYCLES(S)) dut (
      .clk        (clk),
      .reset      (reset),
      .cnt_zero   (cnt_zero),
      .cnt_one    (cnt_one),
      .blank_lz   (blank_lz),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: seg_of = 7'h40; 4'd1: seg_of = 7'h79; 4'd2: seg_of = 7'h24;
         4'd3: seg_of = 7'h30; 4'd4: seg_of = 7'h19; 4'd5: seg_of = 7'h12;
         4'd6: seg_of = 7'h02; 4'd7: seg_of = 7'h78; 4'd8: seg_of = 7'h00;
         4'd9: seg_of = 7'h10; default: seg_of = 7'h3F;
      endcase
   endfunction

   function automatic logic [1:0] exp_an();
      if (m_p < 0 || m_p == 0 || m_p == S) return 2'b11;
      if (m_p < S) return 2'b10;
      if (blank_lz && m_tens == 4'd0) return 2'b11;
      return 2'b01;
   endfunction

   function automatic logic [6:0] exp_seg();
      if (m_p < 0 || m_p == 0 || m_p == S) return 7'h7F;
      if (m_p < S) return seg_of(m_ones);
      if (blank_lz && m_tens == 4'd0) return 7'h7F;
      return seg_of(m_tens);
   endfunction

   function automatic logic exp_fd();
      return m_p == FRAME - 1;
   endfunction

   // Advance one clock edge, update the model from the inputs the DUT sampled.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         m_p = -1; m_ones = 4'd0; m_tens = 4'd0;
      end else if (m_p < 0 || m_p == FRAME - 1) begin
         m_p = 0; m_ones = cnt_zero; m_tens = cnt_one;
      end else begin
         m_p = m_p + 1;
      end
      #1;
   endtask

   // Tick until the model reaches position p (bounded).
   task automatic goto_pos(input int p);
      int k = 0;
      while (m_p != p && k < 2 * FRAME + 2) begin
         tick();
         k++;
      end
      n_tests++;
      if (m_p != p) begin
         n_fail++;
         $display("FAIL goto_pos: reached p=%0d, wanted p=%0d", m_p, p);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; cnt_zero = 4'd5; cnt_one = 4'd0; blank_lz = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (an !== 2'b11 || seg !== 7'h7F || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: an=%b seg=%h fd=%b, expected an=11 seg=7f fd=0",
                     an, seg, frame_done);
         end
      end
      reset = 1'b0;
      tick();
      n_tests++;
      if (an !== 2'b11 || seg !== 7'h7F || frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_p0: an=%b seg=%h fd=%b, expected an=11 seg=7f fd=0",
                  an, seg, frame_done);
      end
      tick();
      n_tests++;
      if (an !== 2'b10 || seg !== 7'h12) begin
         n_fail++;
         $display("FAIL reset_release_ones: an=%b seg=%h, expected an=10 seg=12", an, seg);
      end
   endtask

   task automatic test_normal();
      int pulses = 0;
      cnt_one = 4'd4; cnt_zero = 4'd7; blank_lz = 1'b0;
      goto_pos(FRAME - 1);
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         if (frame_done === 1'b1) pulses++;
         n_tests++;
         if (an !== exp_an() || seg !== exp_seg() || frame_done !== exp_fd()) begin
            n_fail++;
            $display("FAIL normal p=%0d: an=%b seg=%h fd=%b, expected an=%b seg=%h fd=%b",
                     m_p, an, seg, frame_done, exp_an(), exp_seg(), exp_fd());
         end
         if (m_p == 2) begin
            n_tests++;
            if (an !== 2'b10 || seg !== 7'h78) begin
               n_fail++;
               $display("FAIL normal_ones: an=%b seg=%h, expected an=10 seg=78", an, seg);
            end
         end
         if (m_p == 6) begin
            n_tests++;
            if (an !== 2'b01 || seg !== 7'h19) begin
               n_fail++;
               $display("FAIL normal_tens: an=%b seg=%h, expected an=01 seg=19", an, seg);
            end
         end
      end
      n_tests++;
      if (pulses != 2) begin
         n_fail++;
         $display("FAIL normal_frame_done_count: got %0d, expected 2", pulses);
      end
   endtask

   task automatic test_leading_zero();
      cnt_one = 4'd0; cnt_zero = 4'd3; blank_lz = 1'b1;
      goto_pos(FRAME - 1);
      goto_pos(2);
      n_tests++;
      if (an !== 2'b10 || seg !== 7'h30) begin
         n_fail++;
         $display("FAIL lz_ones: an=%b seg=%h, expected an=10 seg=30", an, seg);
      end
      goto_pos(S + 2);
      n_tests++;
      if (an !== 2'b11 || seg !== 7'h7F) begin
         n_fail++;
         $display("FAIL lz_blanked: an=%b seg=%h, expected an=11 seg=7f", an, seg);
      end
      blank_lz = 1'b0;
      tick();
      n_tests++;
      if (an !== 2'b01 || seg !== 7'h40) begin
         n_fail++;
         $display("FAIL lz_off: an=%b seg=%h, expected an=01 seg=40", an, seg);
      end
   endtask

   task automatic test_tear_free();
      cnt_one = 4'd1; cnt_zero = 4'd2; blank_lz = 1'b0;
      goto_pos(FRAME - 1);
      goto_pos(2);
      cnt_zero = 4'd9;
      while (m_p != FRAME - 1) begin
         tick();
         if (m_p > 0 && m_p < S) begin
            n_tests++;
            if (seg !== 7'h24) begin
               n_fail++;
               $display("FAIL tear_hold p=%0d: seg=%h, expected 24", m_p, seg);
            end
         end
      end
      goto_pos(1);
      n_tests++;
      if (an !== 2'b10 || seg !== 7'h10) begin
         n_fail++;
         $display("FAIL tear_next_frame: an=%b seg=%h, expected an=10 seg=10", an, seg);
      end
   endtask

   task automatic test_invalid_bcd();
      cnt_zero = 4'hB; cnt_one = 4'hF; blank_lz = 1'b1;
      goto_pos(FRAME - 1);
      goto_pos(1);
      n_tests++;
      if (an !== 2'b10 || seg !== 7'h3F) begin
         n_fail++;
         $display("FAIL invalid_ones: an=%b seg=%h, expected an=10 seg=3f", an, seg);
      end
      goto_pos(S + 1);
      n_tests++;
      if (an !== 2'b01 || seg !== 7'h3F) begin
         n_fail++;
         $display("FAIL invalid_tens: an=%b seg=%h, expected an=01 seg=3f", an, seg);
      end
   endtask

   task automatic test_reset_mid();
      cnt_zero = 4'd6; cnt_one = 4'd8; blank_lz = 1'b0;
      goto_pos(5);
      reset = 1'b1;
      cnt_zero = 4'd1; cnt_one = 4'd2;
      tick();
      n_tests++;
      if (an !== 2'b11 || seg !== 7'h7F || frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset: an=%b seg=%h fd=%b, expected an=11 seg=7f fd=0",
                  an, seg, frame_done);
      end
      reset = 1'b0;
      for (int i = 0; i < FRAME + 1; i++) begin
         tick();
         n_tests++;
         if (an !== exp_an() || seg !== exp_seg() || frame_done !== exp_fd()) begin
            n_fail++;
            $display("FAIL midreset_restart p=%0d: an=%b seg=%h fd=%b, expected an=%b seg=%h fd=%b",
                     m_p, an, seg, frame_done, exp_an(), exp_seg(), exp_fd());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         cnt_zero = 4'($urandom_range(0, 15));
         cnt_one  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) blank_lz = ~blank_lz;
         reset = ($urandom_range(0, 39) == 0);
         tick();
         n_tests++;
         if (an !== exp_an() || seg !== exp_seg() || frame_done !== exp_fd() || an === 2'b00) begin
            n_fail++;
            $display("FAIL random[%0d] p=%0d: an=%b seg=%h fd=%b, expected an=%b seg=%h fd=%b",
                     i, m_p, an, seg, frame_done, exp_an(), exp_seg(), exp_fd());
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_normal();
      test_leading_zero();
      test_tear_free();
      test_invalid_bcd();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_seg_scanner.md
# bcd_seg_scanner

Two-digit multiplexed 7-segment display driver placed directly downstream of the two-digit BCD counter. It takes the ones digit (`cnt_zero`) and the tens digit (`cnt_one`) and time-multiplexes them onto one shared active-low segment bus with per-digit active-low anode enables. It captures both digits once per refresh frame so the display never tears, inserts a one-cycle blanking gap between digits to suppress ghosting, and optionally blanks a leading zero in the tens position.

## Interface
- `SLOT_CYCLES`, default 4: clock cycles per digit slot, including the blank cycle; legal values are ≥ 2; frame length is 2·SLOT_CYCLES.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `cnt_zero` input, 4 bits: ones digit in BCD.
- `cnt_one` input, 4 bits: tens digit in BCD.
- `blank_lz` input, 1 bit: when 1, a tens digit of 0 is blanked.
- `seg` output, 7 bits: active-low segments {g,f,e,d,c,b,a}; `seg[0]` = a.
- `an` output, 2 bits: active-low digit enables; `an[0]` = ones, `an[1]` = tens.
- `frame_done` output, 1 bit: one-cycle pulse on the last cycle of each frame.

## Operation
- Internal state:
  - slot counter `sc`, 0..SLOT_CYCLES-1;
  - slot select `ss` (0 = ones, 1 = tens);
  - 8-bit shadow register {tens, ones}.
- Frame position `p = ss·SLOT_CYCLES + sc`, range 0..2·SLOT_CYCLES-1.
- `sc` increments by 1 every cycle. When `sc = SLOT_CYCLES-1`, `sc` wraps to 0 and `ss` toggles, so `p` wraps from 2·SLOT_CYCLES-1 back to 0.
- Shadow capture: on the edge that enters `p = 0`, the shadow loads {`cnt_one`, `cnt_zero`}. Input changes at any other time have no effect until the next frame.
- Output behaviour by frame position:
  - `p = 0` (blank): `an` = 11, `seg` = 7F.
  - `p = 1..SLOT_CYCLES-1`: `an` = 10, `seg` = decode(shadow ones).
  - `p = SLOT_CYCLES` (blank): `an` = 11, `seg` = 7F.
  - `p = SLOT_CYCLES+1..2·SLOT_CYCLES-1`: `an` = 01, `seg` = decode(shadow tens). If `blank_lz` = 1 and shadow tens = 0, then instead `an` = 11 and `seg` = 7F.
- `blank_lz` is used live, not shadowed.
- Decode table (hex, active-low): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10. Any value 10..15 (non-BCD) → 3F, a dash with only g lit.
- `frame_done` = 1 exactly when `p = 2·SLOT_CYCLES-1`, otherwise 0.

## Timing
- All outputs are registered. The values shown during position `p` are produced by the same edge that set `p`. There is no combinational path from any input to any output.
- Reset:
  - Any edge that samples `reset` = 1 forces `sc` = 0, `ss` = 0, shadow = 00, `an` = 11, `seg` = 7F, `frame_done` = 0.
  - This holds while reset stays asserted.
- Reset release: the first edge that samples `reset` = 0 enters `p = 0` and captures the shadow.
  - With SLOT_CYCLES = 4, the ones digit is shown from the 2nd edge after release, and the tens digit from the 6th edge.
- Reset mid-frame: the frame is aborted at the next edge and the reset values apply. After release, the frame restarts from `p = 0` with a fresh capture. No partial `frame_done` pulse is produced.
- Inputs sampled on the capture edge itself are the ones captured. A counter update arriving on that same edge is taken.
- Steady state: each digit is lit for SLOT_CYCLES-1 of every 2·SLOT_CYCLES cycles. `an` never equals 00.

## Test plan
- **Reset hold:** assert `reset` for 3 cycles with `cnt_zero` = 5 → `an` = 11, `seg` = 7F, `frame_done` = 0 throughout. After release, cycle `p` = 0 shows `an` = 11.
- **Normal display** (SLOT_CYCLES = 4): `cnt_one` = 4, `cnt_zero` = 7, `blank_lz` = 0 → `p` 1–3: `an` = 10, `seg` = 78; `p` 5–7: `an` = 01, `seg` = 19; `p` 0 and 4: `an` = 11; `frame_done` high only at `p` = 7, i.e. once every 8 cycles.
- **Leading-zero blank:** `cnt_one` = 0, `cnt_zero` = 3, `blank_lz` = 1 → tens slot `an` = 11, `seg` = 7F; ones slot `seg` = 30. With `blank_lz` = 0, tens slot shows `an` = 01, `seg` = 40.
- **Tear-free capture:** change `cnt_zero` from 2 to 9 at `p` = 2 → `seg` stays 24 for the rest of the frame. The next frame shows 10.
- **Invalid BCD:** `cnt_zero` = B, `cnt_one` = F → both slots show `seg` = 3F.
- **Reset mid-frame:** pulse `reset` for 1 cycle at `p` = 5 → next edge gives `an` = 11, `seg` = 7F, no `frame_done`. The frame restarts at `p` = 0 and recaptures the inputs.
